// File: rtl/mux_pkg.sv
// Shared types and constants for the N-way pipelined multiplexer.
package mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    localparam int ERRCNT_W   = 8;
    localparam int ERRCNT_MAX = 255;

endpackage

// File: rtl/mux_nway_comb.sv
// Combinational channel selector: picks one WIDTH-bit lane out of the packed
// input bus, returning zero and an error flag for selector codes with no channel.
module mux_nway_comb
    import mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]          value,
    output logic                      err
);

    // Codes CHANNELS..2^SEL_W-1 match no lane and fall through as errors.
    always_comb begin
        value = '0;
        err   = 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
            if (selector == SEL_W'(k)) begin
                value = data_in[k*WIDTH +: WIDTH];
                err   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_nway_pipe.sv
// N-way multiplexer with a one-cycle, 2-entry skid FIFO on its output.
// Define MUX_NWAY_PIPE_ERRCNT_EN to build the saturating out-of-range counter.
module mux_nway_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          data_out,
    output logic                      sel_err,
    output logic [ERRCNT_W-1:0]       err_count
);

    fifo_state_e        state_q, state_d;
    logic [WIDTH-1:0]   head_data_q, head_data_d;
    logic               head_err_q, head_err_d;
    logic [WIDTH-1:0]   tail_data_q, tail_data_d;
    logic               tail_err_q, tail_err_d;

    logic [WIDTH-1:0]   mux_value;
    logic               mux_err;
    logic               xfer_in;
    logic               xfer_out;

    mux_nway_comb #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_comb (
        .selector (selector),
        .data_in  (data_in),
        .value    (mux_value),
        .err      (mux_err)
    );

    // Handshake outputs depend on the registered state only.
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        data_out  = head_data_q;
        sel_err   = head_err_q;
        xfer_in   = in_valid && in_ready;
        xfer_out  = out_valid && out_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (xfer_in) state_d = ONE;
            ONE: begin
                if (xfer_in && !xfer_out)      state_d = FULL;
                else if (!xfer_in && xfer_out) state_d = EMPTY;
            end
            FULL:  if (xfer_out) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Head is always the oldest entry; the tail only fills when the head is held.
    always_comb begin
        head_data_d = head_data_q;
        head_err_d  = head_err_q;
        tail_data_d = tail_data_q;
        tail_err_d  = tail_err_q;
        case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    head_data_d = mux_value;
                    head_err_d  = mux_err;
                end
            end
            ONE: begin
                if (xfer_in && xfer_out) begin
                    head_data_d = mux_value;
                    head_err_d  = mux_err;
                end else if (xfer_in) begin
                    tail_data_d = mux_value;
                    tail_err_d  = mux_err;
                end
            end
            FULL: begin
                if (xfer_out) begin
                    head_data_d = tail_data_q;
                    head_err_d  = tail_err_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            head_data_q <= '0;
            head_err_q  <= 1'b0;
            tail_data_q <= '0;
            tail_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_err_q  <= head_err_d;
            tail_data_q <= tail_data_d;
            tail_err_q  <= tail_err_d;
        end
    end

`ifdef MUX_NWAY_PIPE_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (xfer_in && mux_err && (err_cnt_q != ERRCNT_W'(ERRCNT_MAX))) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_mux_nway_pipe.sv
// Directed self-checking bench for mux_nway_pipe (4-channel and 3-channel builds).
module tb_mux_nway_pipe;

`ifdef MUX_NWAY_PIPE_ERRCNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;

    logic         in_valid, in_ready, out_valid, out_ready, sel_err;
    logic [1:0]   selector;
    logic [127:0] data_in;
    logic [31:0]  data_out;
    logic [7:0]   err_count;

    logic         in_valid3, in_ready3, out_valid3, out_ready3, sel_err3;
    logic [1:0]   selector3;
    logic [95:0]  data_in3;
    logic [31:0]  data_out3;
    logic [7:0]   err_count3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_nway_pipe #(.WIDTH(32), .CHANNELS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .selector(selector), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .sel_err(sel_err),
        .err_count(err_count)
    );

    mux_nway_pipe #(.WIDTH(32), .CHANNELS(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
        .selector(selector3), .data_in(data_in3), .out_valid(out_valid3),
        .out_ready(out_ready3), .data_out(data_out3), .sel_err(sel_err3),
        .err_count(err_count3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [31:0] v);
        data_in[k*32 +: 32] = v;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        if (!ERRCNT_EN) return 32'd0;
        return (n > 255) ? 32'd255 : 32'(n);
    endfunction

    initial begin
        int oor;
        logic [31:0] v;

        reset      = 1'b1;
        in_valid   = 1'b1;
        selector   = 2'd2;
        data_in    = '0;
        out_ready  = 1'b1;
        in_valid3  = 1'b1;
        selector3  = 2'd3;
        data_in3   = {32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
        out_ready3 = 1'b1;
        set_ch(0, 32'hA0A0_0000);
        set_ch(1, 32'h0000_0B01);
        set_ch(2, 32'hFFFF_FFF0);
        set_ch(3, 32'h8000_0003);

        // Reset held with in_valid high: requests must be ignored.
        step();
        step();
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        check("rst_hold_err_count3", 32'(err_count3), 32'd0);
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_data_out", data_out, 32'd0);
        check("rst_sel_err", 32'(sel_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst3_out_valid", 32'(out_valid3), 32'd0);

        // Single request, one-cycle latency.
        in_valid = 1'b1;
        selector = 2'd2;
        step();
        in_valid = 1'b0;
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_data", data_out, 32'hFFFF_FFF0);
        check("single_sel_err", 32'(sel_err), 32'd0);
        step();
        check("single_drained", 32'(out_valid), 32'd0);

        // Backpressure: three requests, only two fit.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        selector  = 2'd0;
        step();
        check("bp_ready_after1", 32'(in_ready), 32'd1);
        selector = 2'd1;
        step();
        check("bp_ready_after2", 32'(in_ready), 32'd0);
        check("bp_head_ch0", data_out, 32'hA0A0_0000);
        selector = 2'd3;
        step();
        check("bp_ready_held", 32'(in_ready), 32'd0);
        check("bp_head_stable", data_out, 32'hA0A0_0000);
        out_ready = 1'b1;
        step();
        check("bp_out_ch1", data_out, 32'h0000_0B01);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_out_ch3_sign", data_out, 32'h8000_0003);
        check("bp_out_valid3", 32'(out_valid), 32'd1);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Streaming in state ONE: simultaneous in/out for 10 cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        selector  = 2'd0;
        set_ch(0, 32'h1000_0000);
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            v = 32'h1000_0000 + 32'(i);
            selector = 2'(i % 4);
            set_ch(i % 4, v);
            check("stream_prev", data_out, v - 32'd1);
            step();
            check("stream_data", data_out, v);
            check("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 32'(out_valid), 32'd0);

        // Reset while FULL discards both entries.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        selector  = 2'd1;
        step();
        selector  = 2'd3;
        step();
        check("full_before_rst", 32'(in_ready), 32'd0);
        reset = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_data_out", data_out, 32'd0);
        check("midrst_sel_err", 32'(sel_err), 32'd0);
        out_ready = 1'b1;
        step();
        check("midrst_no_stale1", 32'(out_valid), 32'd0);
        step();
        check("midrst_no_stale2", 32'(out_valid), 32'd0);

        // CHANNELS=3: out-of-range selector 3.
        in_valid3 = 1'b1;
        selector3 = 2'd3;
        step();
        oor = 1;
        in_valid3 = 1'b0;
        check("oor_data_zero", data_out3, 32'd0);
        check("oor_sel_err", 32'(sel_err3), 32'd1);
        check("oor_count1", 32'(err_count3), exp_cnt(oor));
        in_valid3 = 1'b1;
        selector3 = 2'd1;
        step();
        check("inrange_data", data_out3, 32'h7FFF_FFFF);
        check("inrange_sel_err", 32'(sel_err3), 32'd0);
        check("inrange_count", 32'(err_count3), exp_cnt(oor));
        selector3 = 2'd2;
        step();
        check("inrange_sign", data_out3, 32'h8000_0000);

        // 299 more out-of-range requests: counter saturates at 255.
        selector3 = 2'd3;
        for (int i = 0; i < 299; i++) begin
            step();
            oor++;
            check("sat_count", 32'(err_count3), exp_cnt(oor));
        end
        check("sat_sel_err", 32'(sel_err3), 32'd1);
        in_valid3 = 1'b0;
        step();
        step();
        check("sat_hold", 32'(err_count3), exp_cnt(300));
        check("cnt4_untouched", 32'(err_count), 32'd0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("cnt_cleared", 32'(err_count3), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
